// File: rtl/flex_fifo.sv
// Parametrised single-clock FIFO with show-ahead read, occupancy count,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module flex_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    w_enable,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    r_enable,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE    = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // A pending read frees a slot this cycle, so a full FIFO may still accept a write.
    assign wr_acc = w_enable && (!full || r_enable) && !clear;
    assign rd_acc = r_enable && !empty && !clear;

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
            end
            count <= count_next;
            // Error flags stick until a flush or reset.
            if (w_enable && full && !r_enable) begin
                overflow <= 1'b1;
            end
            if (r_enable && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is left unreset; an empty FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= w_data;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == CNT_DEPTH);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);
    assign r_data       = empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_flex_fifo.sv
// Directed self-checking bench for flex_fifo: an 8x8 instance for the main
// behaviour and a 16-bit x 4 instance for pointer wrap.
module tb_flex_fifo;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic n_rst;

    logic        clear_a, w_en_a, r_en_a;
    logic [7:0]  w_data_a, r_data_a;
    logic        empty_a, full_a, af_a, ae_a, ovf_a, unf_a;
    logic [3:0]  count_a;

    logic        clear_b, w_en_b, r_en_b;
    logic [15:0] w_data_b, r_data_b;
    logic        empty_b, full_b, af_b, ae_b, ovf_b, unf_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;

    flex_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut_a (
        .clk(tb_clk), .n_rst(n_rst), .clear(clear_a),
        .w_enable(w_en_a), .w_data(w_data_a), .r_enable(r_en_a),
        .r_data(r_data_a), .empty(empty_a), .full(full_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    flex_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut_b (
        .clk(tb_clk), .n_rst(n_rst), .clear(clear_b),
        .w_enable(w_en_b), .w_data(w_data_b), .r_enable(r_en_b),
        .r_data(r_data_b), .empty(empty_b), .full(full_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_a(input logic w, input logic [7:0] d, input logic r, input logic c);
        w_en_a = w; w_data_a = d; r_en_a = r; clear_a = c;
        @(posedge tb_clk);
        #1;
        w_en_a = 1'b0; r_en_a = 1'b0; clear_a = 1'b0;
    endtask

    task automatic apply_b(input logic w, input logic [15:0] d, input logic r);
        w_en_b = w; w_data_b = d; r_en_b = r; clear_b = 1'b0;
        @(posedge tb_clk);
        #1;
        w_en_b = 1'b0; r_en_b = 1'b0;
    endtask

    // Flags for the 8-deep instance: almost_full at >=6, almost_empty at <=2.
    task automatic check_a(input string tag, input int cnt, input logic [7:0] head,
                           input logic ovf, input logic unf);
        check({tag, ".count"},  32'(count_a), 32'(cnt));
        check({tag, ".r_data"}, 32'(r_data_a), 32'(head));
        check({tag, ".empty"},  32'(empty_a), 32'(cnt == 0));
        check({tag, ".full"},   32'(full_a),  32'(cnt == 8));
        check({tag, ".af"},     32'(af_a),    32'(cnt >= 6));
        check({tag, ".ae"},     32'(ae_a),    32'(cnt <= 2));
        check({tag, ".ovf"},    32'(ovf_a),   32'(ovf));
        check({tag, ".unf"},    32'(unf_a),   32'(unf));
    endtask

    // Flags for the 4-deep instance: almost_full at >=2, almost_empty at <=2.
    task automatic check_b(input string tag, input int cnt, input logic [15:0] head,
                           input logic ovf, input logic unf);
        check({tag, ".count"},  32'(count_b), 32'(cnt));
        check({tag, ".r_data"}, 32'(r_data_b), 32'(head));
        check({tag, ".empty"},  32'(empty_b), 32'(cnt == 0));
        check({tag, ".full"},   32'(full_b),  32'(cnt == 4));
        check({tag, ".af"},     32'(af_b),    32'(cnt >= 2));
        check({tag, ".ae"},     32'(ae_b),    32'(cnt <= 2));
        check({tag, ".ovf"},    32'(ovf_b),   32'(ovf));
        check({tag, ".unf"},    32'(unf_b),   32'(unf));
    endtask

    initial begin
        logic [7:0]  exp8;
        logic [15:0] exp16;

        clear_a = 0; w_en_a = 0; r_en_a = 0; w_data_a = '0;
        clear_b = 0; w_en_b = 0; r_en_b = 0; w_data_b = '0;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        check_a("reset_a", 0, 8'h00, 0, 0);
        check_b("reset_b", 0, 16'h0000, 0, 0);
        #13 n_rst = 1'b1;

        // Single write then pop
        apply_a(1, 8'hFF, 0, 0);
        check_a("wr1", 1, 8'hFF, 0, 0);
        apply_a(0, 8'h00, 1, 0);
        check_a("pop1", 0, 8'h00, 0, 0);

        // Fill to full, then drain in order
        for (int i = 0; i < 8; i++) begin
            apply_a(1, 8'(255 - i), 0, 0);
            check_a("fill", i + 1, 8'hFF, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            exp8 = (i < 7) ? 8'(254 - i) : 8'h00;
            apply_a(0, 8'h00, 1, 0);
            check_a("drain", 7 - i, exp8, 0, 0);
        end

        // Overflow on full, then simultaneous read/write while full
        for (int i = 0; i < 8; i++) apply_a(1, 8'(255 - i), 0, 0);
        apply_a(1, 8'hAA, 0, 0);
        check_a("ovf", 8, 8'hFF, 1, 0);
        apply_a(1, 8'hBB, 1, 0);
        check_a("full_rw", 8, 8'hFE, 1, 0);
        for (int i = 0; i < 8; i++) begin
            exp8 = (i < 7) ? 8'(254 - i) : 8'hBB;
            check("drain2.head", 32'(r_data_a), 32'(exp8));
            apply_a(0, 8'h00, 1, 0);
        end
        check_a("drain2_end", 0, 8'h00, 1, 0);

        // Flush, underflow, read+write on empty
        apply_a(0, 8'h00, 0, 1);
        check_a("clr0", 0, 8'h00, 0, 0);
        apply_a(0, 8'h00, 1, 0);
        check_a("unf", 0, 8'h00, 0, 1);
        apply_a(1, 8'h5A, 1, 0);
        check_a("unf_rw", 1, 8'h5A, 0, 1);

        // Partial fill with overflow set, then clear alongside a write
        apply_a(0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) apply_a(1, 8'(i * 17), 0, 0);
        apply_a(1, 8'hEE, 0, 0);
        for (int i = 0; i < 3; i++) apply_a(0, 8'h00, 1, 0);
        check_a("part5", 5, 8'h33, 1, 0);
        apply_a(1, 8'h77, 0, 1);
        check_a("clr_w", 0, 8'h00, 0, 0);
        apply_a(0, 8'h00, 0, 0);
        check_a("clr_idle", 0, 8'h00, 0, 0);

        // Sustained read+write at occupancy 3
        for (int i = 0; i < 3; i++) apply_a(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply_a(1, 8'(8'h43 + i), 1, 0);
            check_a("stream", 3, 8'(8'h41 + i), 0, 0);
        end
        apply_a(0, 8'h00, 0, 1);

        // Asynchronous reset between edges with a write pending
        apply_a(1, 8'hA1, 0, 0);
        apply_a(1, 8'hA2, 0, 0);
        apply_a(1, 8'hA3, 0, 0);
        apply_a(1, 8'hEE, 1, 0);
        check_a("pre_rst", 3, 8'hA2, 0, 0);
        w_en_a = 1'b1; w_data_a = 8'hCC;
        #2 n_rst = 1'b0;
        #2;
        check_a("async_rst", 0, 8'h00, 0, 0);
        #2 n_rst = 1'b1;
        apply_a(1, 8'h11, 0, 0);
        check_a("post_rst", 1, 8'h11, 0, 0);
        apply_a(0, 8'h00, 1, 0);
        check_a("post_rst_pop", 0, 8'h00, 0, 0);

        // 16-bit x 4 instance: offset pointers by one, then fill/drain across the wrap
        apply_b(1, 16'h1234, 0);
        apply_b(0, 16'h0000, 1);
        check_b("b_offset", 0, 16'h0000, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++) begin
                apply_b(1, 16'(16'hC000 + r * 16 + j), 0);
                check_b("b_fill", j + 1, 16'(16'hC000 + r * 16), 0, 0);
            end
            for (int j = 0; j < 4; j++) begin
                exp16 = (j < 3) ? 16'(16'hC000 + r * 16 + j + 1) : 16'h0000;
                apply_b(0, 16'h0000, 1);
                check_b("b_drain", 3 - j, exp16, 0, 0);
            end
        end
        apply_b(0, 16'h0000, 1);
        check_b("b_unf", 0, 16'h0000, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
